// File: rtl/uart_tx_fifo.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | uart_tx_fifo : byte FIFO that launches queued bytes into uart_tx        |
// | Revision 1.0                                                            |
// +-------------------------------------------------------------------------+
module uart_tx_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              i_Clock,
  input  logic              i_Rst_n,
  input  logic              i_Wr_En,
  input  logic [7:0]        i_Wr_Byte,
  output logic              o_Full,
  output logic              o_Empty,
  output logic [ADDR_W:0]   o_Count,
  output logic              o_Overflow,
  input  logic              i_Clr_Ovf,
  output logic              o_Tx_DV,
  output logic [7:0]        o_Tx_Byte,
  input  logic              i_Tx_Done,
  output logic              o_Busy
);

  localparam int                CNT_W    = ADDR_W + 1;
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  logic [7:0]        mem [DEPTH];
  state_e            state_q,   state_d;
  logic [ADDR_W-1:0] wr_ptr_q,  wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q,  rd_ptr_d;
  logic [CNT_W-1:0]  count_q,   count_d;
  logic              ovf_q,     ovf_d;
  logic              tx_dv_q,   tx_dv_d;
  logic [7:0]        tx_byte_q, tx_byte_d;
  logic              busy_q,    busy_d;

  logic full, empty, wr_ok, launch;

  always_comb begin
    full   = (count_q == FULL_CNT);
    empty  = (count_q == '0);
    wr_ok  = i_Wr_En & ~full;
    launch = (state_q == ST_IDLE) & ~empty;

    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    tx_dv_d   = launch;
    tx_byte_d = tx_byte_q;
    busy_d    = busy_q;

    if (wr_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (launch) begin
      rd_ptr_d  = rd_ptr_q + PTR_ONE;
      tx_byte_d = mem[rd_ptr_q];
    end

    case ({wr_ok, launch})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    // A dropped write in the same cycle as a clear keeps the flag set.
    if (i_Wr_En & full)  ovf_d = 1'b1;
    else if (i_Clr_Ovf)  ovf_d = 1'b0;

    case (state_q)
      ST_IDLE: if (launch) begin
        state_d = ST_BUSY;
        busy_d  = 1'b1;
      end
      ST_BUSY: if (i_Tx_Done) state_d = ST_GAP;
      ST_GAP: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q   <= ST_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      tx_dv_q   <= 1'b0;
      tx_byte_q <= 8'h00;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      tx_dv_q   <= tx_dv_d;
      tx_byte_q <= tx_byte_d;
      busy_q    <= busy_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge i_Clock) begin
    if (wr_ok) mem[wr_ptr_q] <= i_Wr_Byte;
  end

  assign o_Full     = full;
  assign o_Empty    = empty;
  assign o_Count    = count_q;
  assign o_Overflow = ovf_q;
  assign o_Tx_DV    = tx_dv_q;
  assign o_Tx_Byte  = tx_byte_q;
  assign o_Busy     = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_uart_tx_fifo : directed bench, uart_tx emulated by i_Tx_Done pulses  |
// | Revision 1.0                                                            |
// +-------------------------------------------------------------------------+
module tb_uart_tx_fifo;

  logic       clk;
  logic       rst_n;
  logic       wr_en;
  logic [7:0] wr_byte;
  logic       clr_ovf;
  logic       tx_done;
  logic       full, empty, ovf, tx_dv, busy;
  logic [4:0] count;
  logic [7:0] tx_byte;

  int n_cmp = 0;
  int n_err = 0;

  uart_tx_fifo #(.DEPTH(16), .ADDR_W(4)) dut (
    .i_Clock    (clk),
    .i_Rst_n    (rst_n),
    .i_Wr_En    (wr_en),
    .i_Wr_Byte  (wr_byte),
    .o_Full     (full),
    .o_Empty    (empty),
    .o_Count    (count),
    .o_Overflow (ovf),
    .i_Clr_Ovf  (clr_ovf),
    .o_Tx_DV    (tx_dv),
    .o_Tx_Byte  (tx_byte),
    .i_Tx_Done  (tx_done),
    .o_Busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    wr_en = 0; wr_byte = 0; clr_ovf = 0; tx_done = 0;
    rst_n = 0;
    tick();
    rst_n = 1;
    tick();
  endtask

  // Emulates uart_tx finishing a frame: a few busy cycles then a done pulse.
  task automatic frame_done();
    repeat (3) tick();
    tx_done = 1;
    tick();
    tx_done = 0;
  endtask

  task automatic test_reset();
    wr_en = 0; wr_byte = 0; clr_ovf = 0; tx_done = 0;
    rst_n = 1;
    #1 rst_n = 0;
    #1;
    n_cmp++;
    if ({empty, full, count, ovf, tx_dv, tx_byte, busy} !== {1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 8'h00, 1'b0}) begin
      n_err++;
      $display("FAIL reset_state: got e=%b f=%b c=%0d o=%b dv=%b b=%h busy=%b, want e=1 f=0 c=0 o=0 dv=0 b=00 busy=0",
               empty, full, count, ovf, tx_dv, tx_byte, busy);
    end
    tick();
    rst_n = 1;
    tick();
  endtask

  task automatic test_single();
    do_reset();
    wr_en = 1; wr_byte = 8'hAB;
    tick();
    wr_en = 0;
    n_cmp++;
    if (count !== 5'd1 || tx_dv !== 1'b0) begin
      n_err++; $display("FAIL single_stored: count=%0d dv=%b, want 1 0", count, tx_dv);
    end
    tick();
    n_cmp++;
    if (tx_dv !== 1'b1 || tx_byte !== 8'hAB || busy !== 1'b1 || empty !== 1'b1) begin
      n_err++; $display("FAIL single_launch: dv=%b byte=%h busy=%b empty=%b, want 1 ab 1 1", tx_dv, tx_byte, busy, empty);
    end
    tick();
    n_cmp++;
    if (tx_dv !== 1'b0 || tx_byte !== 8'hAB) begin
      n_err++; $display("FAIL single_pulse_width: dv=%b byte=%h, want 0 ab", tx_dv, tx_byte);
    end
    frame_done();
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++; $display("FAIL single_busy_gap: busy=%b, want 1", busy);
    end
    tick();
    n_cmp++;
    if (busy !== 1'b0 || tx_dv !== 1'b0) begin
      n_err++; $display("FAIL single_busy_fall: busy=%b dv=%b, want 0 0", busy, tx_dv);
    end
  endtask

  task automatic test_burst();
    int peak = 0;
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      wr_en = 1; wr_byte = 8'(i);
      tick();
      if (int'(count) > peak) peak = int'(count);
      if (i == 2) begin
        n_cmp++;
        if (tx_dv !== 1'b1 || tx_byte !== 8'h01) begin
          n_err++; $display("FAIL burst_first: dv=%b byte=%h, want 1 01", tx_dv, tx_byte);
        end
      end
    end
    wr_en = 0;
    n_cmp++;
    if (peak != 4) begin
      n_err++; $display("FAIL burst_peak_count: got %0d, want 4", peak);
    end
    for (int k = 2; k <= 5; k++) begin
      frame_done();
      tick();
      n_cmp++;
      if (tx_dv !== 1'b0) begin
        n_err++; $display("FAIL burst_early_launch%0d: dv=%b, want 0", k, tx_dv);
      end
      tick();
      n_cmp++;
      if (tx_dv !== 1'b1 || tx_byte !== 8'(k)) begin
        n_err++; $display("FAIL burst_launch%0d: dv=%b byte=%h, want 1 %h", k, tx_dv, tx_byte, 8'(k));
      end
    end
    n_cmp++;
    if (empty !== 1'b1 || count !== 5'd0) begin
      n_err++; $display("FAIL burst_empty: empty=%b count=%0d, want 1 0", empty, count);
    end
    frame_done();
    tick();
    n_cmp++;
    if (busy !== 1'b0 || tx_dv !== 1'b0) begin
      n_err++; $display("FAIL burst_idle: busy=%b dv=%b, want 0 0", busy, tx_dv);
    end
  endtask

  task automatic test_full();
    bit seen = 0;
    do_reset();
    for (int i = 0; i < 18; i++) begin
      wr_en = 1; wr_byte = 8'(16 + i);
      tick();
      if (i == 16) begin
        n_cmp++;
        if (full !== 1'b1 || count !== 5'd16 || ovf !== 1'b0) begin
          n_err++; $display("FAIL full_reached: full=%b count=%0d ovf=%b, want 1 16 0", full, count, ovf);
        end
      end
    end
    n_cmp++;
    if (ovf !== 1'b1 || count !== 5'd16 || full !== 1'b1) begin
      n_err++; $display("FAIL full_overflow: ovf=%b count=%0d full=%b, want 1 16 1", ovf, count, full);
    end
    wr_byte = 8'h99; clr_ovf = 1;
    tick();
    n_cmp++;
    if (ovf !== 1'b1) begin
      n_err++; $display("FAIL ovf_set_wins: ovf=%b, want 1", ovf);
    end
    wr_en = 0;
    tick();
    clr_ovf = 0;
    n_cmp++;
    if (ovf !== 1'b0) begin
      n_err++; $display("FAIL ovf_clear: ovf=%b, want 0", ovf);
    end
    for (int k = 1; k <= 16; k++) begin
      frame_done();
      tick();
      tick();
      n_cmp++;
      if (tx_dv !== 1'b1 || tx_byte !== 8'(16 + k)) begin
        n_err++; $display("FAIL full_drain%0d: dv=%b byte=%h, want 1 %h", k, tx_dv, tx_byte, 8'(16 + k));
      end
    end
    frame_done();
    repeat (6) begin
      tick();
      if (tx_dv === 1'b1) seen = 1;
    end
    n_cmp++;
    if (seen || empty !== 1'b1) begin
      n_err++; $display("FAIL full_dropped_absent: extra_launch=%b empty=%b, want 0 1", seen, empty);
    end
  endtask

  task automatic test_wrap();
    int got = 0;
    int budget = 0;
    do_reset();
    fork
      begin
        for (int c = 0; c < 4; c++) begin
          for (int j = 0; j < 10; j++) begin
            wr_en = 1; wr_byte = 8'(c * 10 + j);
            tick();
          end
          wr_en = 0;
          repeat (60) tick();
        end
      end
      begin
        while (got < 40 && budget < 3000) begin
          tick();
          budget++;
          if (tx_dv === 1'b1) begin
            n_cmp++;
            if (tx_byte !== 8'(got)) begin
              n_err++; $display("FAIL wrap_order%0d: byte=%h, want %h", got, tx_byte, 8'(got));
            end
            got++;
            repeat (2) tick();
            tx_done = 1;
            tick();
            tx_done = 0;
          end
        end
      end
    join
    n_cmp++;
    if (got != 40 || ovf !== 1'b0) begin
      n_err++; $display("FAIL wrap_total: bytes=%0d ovf=%b, want 40 0", got, ovf);
    end
  endtask

  task automatic test_simul();
    logic [7:0] exp_q [3];
    exp_q[0] = 8'h52; exp_q[1] = 8'h53; exp_q[2] = 8'h77;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      wr_en = 1; wr_byte = 8'(8'h50 + i);
      tick();
    end
    wr_en = 0;
    frame_done();
    tick();
    n_cmp++;
    if (count !== 5'd3 || tx_dv !== 1'b0) begin
      n_err++; $display("FAIL simul_pre: count=%0d dv=%b, want 3 0", count, tx_dv);
    end
    wr_en = 1; wr_byte = 8'h77;
    tick();
    wr_en = 0;
    n_cmp++;
    if (tx_dv !== 1'b1 || tx_byte !== 8'h51 || count !== 5'd3) begin
      n_err++; $display("FAIL simul_launch: dv=%b byte=%h count=%0d, want 1 51 3", tx_dv, tx_byte, count);
    end
    for (int k = 0; k < 3; k++) begin
      frame_done();
      tick();
      tick();
      n_cmp++;
      if (tx_dv !== 1'b1 || tx_byte !== exp_q[k]) begin
        n_err++; $display("FAIL simul_drain%0d: dv=%b byte=%h, want 1 %h", k, tx_dv, tx_byte, exp_q[k]);
      end
    end
    n_cmp++;
    if (empty !== 1'b1) begin
      n_err++; $display("FAIL simul_empty: empty=%b, want 1", empty);
    end
  endtask

  task automatic test_reset_mid();
    bit seen = 0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      wr_en = 1; wr_byte = 8'(8'h61 + i);
      tick();
    end
    wr_en = 0;
    frame_done();
    tick();
    tick();
    n_cmp++;
    if (tx_dv !== 1'b1 || tx_byte !== 8'h62) begin
      n_err++; $display("FAIL mid_second_launch: dv=%b byte=%h, want 1 62", tx_dv, tx_byte);
    end
    // Reset lands mid-cycle while the launch pulse is high.
    #2 rst_n = 0;
    #1;
    n_cmp++;
    if ({empty, full, count, ovf, tx_dv, tx_byte, busy} !== {1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 8'h00, 1'b0}) begin
      n_err++;
      $display("FAIL mid_async_reset: got e=%b f=%b c=%0d o=%b dv=%b b=%h busy=%b, want e=1 f=0 c=0 o=0 dv=0 b=00 busy=0",
               empty, full, count, ovf, tx_dv, tx_byte, busy);
    end
    tick();
    rst_n = 1;
    tick();
    tx_done = 1;
    tick();
    tx_done = 0;
    repeat (5) begin
      tick();
      if (tx_dv === 1'b1 || busy === 1'b1) seen = 1;
    end
    n_cmp++;
    if (seen) begin
      n_err++; $display("FAIL mid_stale_done: activity after stale done=1, want 0");
    end
    wr_en = 1; wr_byte = 8'h3C;
    tick();
    wr_en = 0;
    tick();
    n_cmp++;
    if (tx_dv !== 1'b1 || tx_byte !== 8'h3C) begin
      n_err++; $display("FAIL mid_fresh_launch: dv=%b byte=%h, want 1 3c", tx_dv, tx_byte);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_full();
    test_wrap();
    test_simul();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
